instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
Moore FSM that sequences the register-file/ALU datapath for the simple RISC instruction set (MOV imm, MOV reg, ADD, CMP, AND, MVN).
- Consumes opcode/op fields from the instruction decoder.
- Drives the decoder's one-hot register-select (nsel) plus every datapath load/select/write strobe.
- Sits between the instruction register and the datapath; the top level starts it with a one-cycle start pulse.

Parameters:
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- s  in  1  start; sampled only in WAIT.
- opcode  in  3  instruction bits [15:13].
- op  in  2  instruction bits [12:11].
- w  out  1  high only in WAIT (ready for s).
- nsel  out  3  one-hot register select: 001 = Rn, 010 = Rd, 100 = Rm, 000 = none.
- loada  out  1  load A register.
- loadb  out  1  load B register.
- loadc  out  1  load C register.
- loads  out  1  load status flags.
- asel  out  1  1 = zero A operand.
- bsel  out  1  1 = sximm5 as B operand.
- vsel  out  2  writeback source: 00 = C, 01 = PC (zero), 10 = sximm8, 11 = mdata.
- write  out  1  register file write enable.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset is synchronous: on any clk edge with reset = 1, state goes to WAIT and retired goes to 0, overriding all other inputs. A reset mid-instruction aborts it and produces no write.
- Outputs are pure Moore, decoded from state only.
- Reset/WAIT output values: w = 1; every other strobe, nsel, and vsel = 0.
- States: WAIT, DECODE, WR_IMM, GET_A, GET_B, ALU, WR_RD, ERR (ERR exists only with the optional feature).
- WAIT: stay while s = 0. On s = 1, go to DECODE. opcode/op must be stable from the s cycle until the instruction returns to WAIT.
- DECODE: all strobes 0. Next state:
  - {110, 10} -> WR_IMM.
  - {110, 00} or {101, 11} -> GET_B.
  - {101, 00 / 01 / 10} -> GET_A.
  - Anything else is unsupported -> WAIT.
- WR_IMM: nsel = 001, vsel = 10, write = 1; -> WAIT.
- GET_A: nsel = 001, loada = 1; -> GET_B.
- GET_B: nsel = 100, loadb = 1; -> ALU.
- ALU: bsel = 0.
  - asel = 1 for MOV reg and MVN; otherwise asel = 0.
  - CMP: loads = 1, loadc = 0; -> WAIT.
  - All other instructions: loadc = 1; -> WR_RD.
- WR_RD: nsel = 100? No: nsel = 010, vsel = 00, write = 1; -> WAIT.
- retired increments by 1 on every transition into WAIT from WR_IMM, WR_RD, or ALU (CMP). It wraps at 2^CNT_W - 1 -> 0. Unsupported instructions do not increment it.
- Latency from the s cycle to w = 1 again:
  - MOV imm: 3 cycles.
  - MOV reg / MVN: 5 cycles.
  - ADD / AND: 6 cycles.
  - CMP: 5 cycles.
- At most one of loada/loadb/loadc/write is high in any state. nsel is never multi-hot.
- s asserted outside WAIT is ignored, with no queuing.

Optional Feature:
- Macro: INSTR_SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - DECODE on an unsupported {opcode, op} goes to ERR.
  - ERR drives all strobes 0 and w = 0, and stays there until reset (sticky).
  - An extra output err (1 bit) is 1 exactly in ERR.
- Undefined:
  - Unsupported instructions return to WAIT as a 2-cycle no-op.
  - No ERR state and no err port.

Decomposition:
- Shared package holds:
  - Opcode/op constants (OP_MOV = 110, OP_ALU = 101, ALU_ADD/CMP/AND/MVN).
  - State encoding constants.
  - NSEL_RN / NSEL_RD / NSEL_RM one-hot constants.
  - VSEL_C / VSEL_PC / VSEL_IMM / VSEL_MDATA codes.
- Sub-module instr_seq_outdec: a combinational state -> strobe decode table, instantiated once.
- The state register, next-state logic, and retired counter stay in instr_sequencer.

Test Plan:
- MOV R0,#7 (0xD007 fields: opcode 110, op 10), pulse s:
  - DECODE, then WR_IMM with nsel = 001, vsel = 10, write = 1.
  - w = 1 on the 3rd edge after s; retired = 1.
- ADD R2,R1,R0 (0xA140):
  - Sequence GET_A(nsel 001, loada) -> GET_B(nsel 100, loadb) -> ALU(asel 0, loadc) -> WR_RD(nsel 010, vsel 00, write).
  - 6 cycles total; retired increments.
- CMP (opcode 101, op 01):
  - ALU state has loads = 1, loadc = 0; never enters WR_RD; write stays 0 throughout.
- MOV reg and MVN:
  - Skip GET_A; ALU state has asel = 1; 5 cycles total.
- Reset asserted during GET_B of an ADD:
  - Next edge gives WAIT, w = 1, all strobes 0, retired = 0, no write pulse observed.
- Opcode 111 with s:
  - Without the macro: back in WAIT after 2 cycles, retired unchanged.
  - With INSTR_SEQ_ILLEGAL_TRAP_EN: err = 1, w = 0, and the block stays there despite repeated s until reset.
- Also assert s during ALU: it is ignored and the state sequence is unchanged.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared constants, state/kind encodings and strobe bundle for the instruction sequencer.
// Optional illegal-instruction trap is enabled by defining INSTR_SEQ_ILLEGAL_TRAP_EN.
package instr_sequencer_pkg;

    localparam logic [2:0] OP_MOV     = 3'b110;
    localparam logic [2:0] OP_ALU     = 3'b101;

    localparam logic [1:0] MOV_IMM_OP = 2'b10;
    localparam logic [1:0] MOV_REG_OP = 2'b00;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_CMP    = 2'b01;
    localparam logic [1:0] ALU_AND    = 2'b10;
    localparam logic [1:0] ALU_MVN    = 2'b11;

    localparam logic [2:0] NSEL_NONE  = 3'b000;
    localparam logic [2:0] NSEL_RN    = 3'b001;
    localparam logic [2:0] NSEL_RD    = 3'b010;
    localparam logic [2:0] NSEL_RM    = 3'b100;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WR_IMM = 3'd2,
        S_GET_A  = 3'd3,
        S_GET_B  = 3'd4,
        S_ALU    = 3'd5,
        S_WR_RD  = 3'd6
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
        ,
        S_ERR    = 3'd7
`endif
    } state_t;

    typedef enum logic [2:0] {
        K_MOV_IMM = 3'd0,
        K_MOV_REG = 3'd1,
        K_ADD     = 3'd2,
        K_CMP     = 3'd3,
        K_AND     = 3'd4,
        K_MVN     = 3'd5,
        K_BAD     = 3'd6
    } instr_kind_t;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic       write;
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
        logic       err;
`endif
    } ctrl_t;

    // Map the {opcode, op} fields onto the supported instruction set.
    function automatic instr_kind_t classify(input logic [2:0] opcode, input logic [1:0] op);
        instr_kind_t kind;
        kind = K_BAD;
        case (opcode)
            OP_MOV: begin
                case (op)
                    MOV_IMM_OP: kind = K_MOV_IMM;
                    MOV_REG_OP: kind = K_MOV_REG;
                    default:    kind = K_BAD;
                endcase
            end
            OP_ALU: begin
                case (op)
                    ALU_ADD: kind = K_ADD;
                    ALU_CMP: kind = K_CMP;
                    ALU_AND: kind = K_AND;
                    ALU_MVN: kind = K_MVN;
                    default: kind = K_BAD;
                endcase
            end
            default: kind = K_BAD;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/instr_seq_outdec.sv
// Combinational state -> datapath strobe table for the instruction sequencer.
// Adds the err strobe when INSTR_SEQ_ILLEGAL_TRAP_EN is defined.
module instr_seq_outdec
    import instr_sequencer_pkg::*;
(
    input  state_t      state,
    input  instr_kind_t kind,
    output ctrl_t       ctrl
);

    // Strobe decode; kind only matters in ALU, where opcode is held stable.
    always_comb begin
        ctrl      = '0;
        ctrl.nsel = NSEL_NONE;
        ctrl.vsel = VSEL_C;
        case (state)
            S_WAIT: begin
                ctrl.w = 1'b1;
            end
            S_DECODE: begin
                ctrl.w = 1'b0;
            end
            S_WR_IMM: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.vsel  = VSEL_IMM;
                ctrl.write = 1'b1;
            end
            S_GET_A: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.loada = 1'b1;
            end
            S_GET_B: begin
                ctrl.nsel  = NSEL_RM;
                ctrl.loadb = 1'b1;
            end
            S_ALU: begin
                ctrl.bsel = 1'b0;
                if ((kind == K_MOV_REG) || (kind == K_MVN)) begin
                    ctrl.asel = 1'b1;
                end else begin
                    ctrl.asel = 1'b0;
                end
                if (kind == K_CMP) begin
                    ctrl.loads = 1'b1;
                end else begin
                    ctrl.loadc = 1'b1;
                end
            end
            S_WR_RD: begin
                ctrl.nsel  = NSEL_RD;
                ctrl.vsel  = VSEL_C;
                ctrl.write = 1'b1;
            end
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
            S_ERR: begin
                ctrl.err = 1'b1;
            end
`endif
            default: begin
                ctrl.w = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Moore sequencer driving the register-file/ALU datapath for the simple RISC ISA.
// Define INSTR_SEQ_ILLEGAL_TRAP_EN to trap unsupported instructions in a sticky ERR state.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [2:0]       opcode,
    input  logic [1:0]       op,
    output logic             w,
    output logic [2:0]       nsel,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       vsel,
    output logic             write,
    output logic [CNT_W-1:0] retired
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
    ,
    output logic             err
`endif
);

    state_t           state_r;
    state_t           state_next_s;
    instr_kind_t      kind_s;
    logic             retire_s;
    ctrl_t            ctrl_next_s;
    ctrl_t            ctrl_r;
    logic [CNT_W-1:0] retired_r;

    assign kind_s = classify(opcode, op);

    // Next-state selection and detection of instruction completion.
    always_comb begin
        state_next_s = state_r;
        retire_s     = 1'b0;
        case (state_r)
            S_WAIT: begin
                if (s) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_DECODE: begin
                case (kind_s)
                    K_MOV_IMM:        state_next_s = S_WR_IMM;
                    K_MOV_REG, K_MVN: state_next_s = S_GET_B;
                    K_ADD, K_CMP, K_AND: state_next_s = S_GET_A;
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
                    default:          state_next_s = S_ERR;
`else
                    default:          state_next_s = S_WAIT;
`endif
                endcase
            end
            S_WR_IMM: begin
                state_next_s = S_WAIT;
                retire_s     = 1'b1;
            end
            S_GET_A: begin
                state_next_s = S_GET_B;
            end
            S_GET_B: begin
                state_next_s = S_ALU;
            end
            S_ALU: begin
                if (kind_s == K_CMP) begin
                    state_next_s = S_WAIT;
                    retire_s     = 1'b1;
                end else begin
                    state_next_s = S_WR_RD;
                end
            end
            S_WR_RD: begin
                state_next_s = S_WAIT;
                retire_s     = 1'b1;
            end
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
            S_ERR: begin
                state_next_s = S_ERR;
            end
`endif
            default: begin
                state_next_s = S_WAIT;
            end
        endcase
    end

    // Strobes are decoded from the upcoming state so they land in a register with it.
    instr_seq_outdec u_outdec (
        .state (state_next_s),
        .kind  (kind_s),
        .ctrl  (ctrl_next_s)
    );

    // State, registered strobes and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_WAIT;
            ctrl_r    <= '0;
            ctrl_r.w  <= 1'b1;
            retired_r <= '0;
        end else begin
            state_r <= state_next_s;
            ctrl_r  <= ctrl_next_s;
            if (retire_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    assign w       = ctrl_r.w;
    assign nsel    = ctrl_r.nsel;
    assign loada   = ctrl_r.loada;
    assign loadb   = ctrl_r.loadb;
    assign loadc   = ctrl_r.loadc;
    assign loads   = ctrl_r.loads;
    assign asel    = ctrl_r.asel;
    assign bsel    = ctrl_r.bsel;
    assign vsel    = ctrl_r.vsel;
    assign write   = ctrl_r.write;
    assign retired = retired_r;
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
    assign err     = ctrl_r.err;
`endif

endmodule
